uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter with round-robin arbitration.
// A grant captures the byte and owner, then one 8N1/8N2 frame is shifted out
// LSB first. Bit timing comes from rising edges of an external baud strobe.
module uart_tx_arbiter #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    STOP
  } state_e;

  // Value of the stop counter on the final stop bit (0 for one stop bit, 1 for two).
  localparam logic LAST_STOP = (STOP_BITS == 2);

  logic [1:0] rstSync_q;
  logic       tickPrev_q;
  state_e     state_q;
  logic [7:0] byte_q;
  logic [2:0] bitIdx_q;
  logic       stopCnt_q;
  logic       owner_q;
  logic       favour1_q;

  logic       bitEvent;
  logic       runEn;
  logic       pick1_d;

  // A held-high strobe counts only once, on its rising cycle.
  assign bitEvent = baud_tick & ~tickPrev_q;
  assign runEn    = rstSync_q[1];

  // Arbitration: on contention, favour1_q names the requester not granted last.
  always_comb begin
    pick1_d = req1;
    if (req0 && req1) begin
      pick1_d = favour1_q;
    end
  end

  // Reset release is synchronised so the FSM never leaves IDLE on a partial release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  // Baud strobe history used for rising-edge event detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickPrev_q <= 1'b0;
    end else begin
      tickPrev_q <= baud_tick;
    end
  end

  // Frame FSM with registered grant, serial line, busy and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      bitIdx_q  <= 3'd0;
      stopCnt_q <= 1'b0;
      owner_q   <= 1'b0;
      favour1_q <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (runEn && (req0 || req1)) begin
            gnt0      <= ~pick1_d;
            gnt1      <= pick1_d;
            byte_q    <= pick1_d ? data1 : data0;
            owner_q   <= pick1_d;
            favour1_q <= ~pick1_d;
            busy      <= 1'b1;
            state_q   <= ALIGN;
          end
        end
        ALIGN: begin
          if (bitEvent) begin
            tx      <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bitEvent) begin
            tx       <= byte_q[0];
            bitIdx_q <= 3'd0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bitEvent) begin
            if (bitIdx_q == 3'd7) begin
              tx        <= 1'b1;
              stopCnt_q <= 1'b0;
              state_q   <= STOP;
            end else begin
              tx       <= byte_q[bitIdx_q + 3'd1];
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bitEvent) begin
            if (stopCnt_q == LAST_STOP) begin
              done    <= 1'b1;
              done_id <= owner_q;
              busy    <= 1'b0;
              state_q <= IDLE;
            end else begin
              stopCnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
